dsp_op_sequencer: RTL and testbench

Command-side initiator for the DSP multiply-accumulate slice. It accepts operation commands over a valid/ready interface and drives the DSP's `start`/operand/mode ports, one operation per cycle. It tracks in-flight operations and captures `out` whenever the DSP raises `compare_res`. Results go into a credit-protected FIFO that drains over a valid/ready result port. The block sits between the accelerator control path and the DSP, and is the only agent driving DSP inputs.

---
 rtl/dsp_op_sequencer.sv | 113 +++++++++++
 tb/tb_dsp_op_sequencer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_op_sequencer.sv
// dsp_op_sequencer: issues MAC commands to the DSP slice, tracks in-flight ops and queues results in a credit-protected FIFO
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   cmd_valid/cmd_ready, cmd_*    command handshake, operands and DSP control fields
//   dsp_*  (out)                  registered DSP drive; dsp_start pulses once per issued op
//   dsp_compare_res, dsp_out      DSP result strobe and data
//   res_valid/res_ready/res_data  result FIFO head
//   err_illegal, err_spurious     sticky error flags
module dsp_op_sequencer #(
    parameter int WIDTH      = 16,
    parameter int SHIFT_BITS = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [WIDTH-1:0]       cmd_a,
    input  logic [WIDTH-1:0]       cmd_b,
    input  logic [2*WIDTH-1:0]     cmd_c,
    input  logic [1:0]             cmd_mode,
    input  logic                   cmd_mac,
    input  logic                   cmd_shift_en,
    input  logic                   cmd_shift_dir,
    input  logic                   cmd_piped,
    input  logic [SHIFT_BITS-1:0]  cmd_shift_amt,
    output logic                   dsp_start,
    output logic                   dsp_mac,
    output logic                   dsp_shift_enable,
    output logic                   dsp_shift_dir,
    output logic                   dsp_piped_final_addition,
    output logic [WIDTH-1:0]       dsp_aa,
    output logic [WIDTH-1:0]       dsp_bb,
    output logic [2*WIDTH-1:0]     dsp_cc,
    output logic [1:0]             dsp_mode,
    output logic [SHIFT_BITS-1:0]  dsp_shift_amount,
    input  logic                   dsp_compare_res,
    input  logic [2*WIDTH-1:0]     dsp_out,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [2*WIDTH-1:0]     res_data,
    output logic                   err_illegal,
    output logic                   err_spurious
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0]          count, inflight;
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [2:0]           quiet_cnt;
    logic [2*WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [AW+1:0]        used;
    logic                 illegal, cfg_match, accept, issue, push, pop;

    assign used      = {1'b0, count} + {1'b0, inflight};
    assign illegal   = cmd_mode == 2'b11;
    assign cfg_match = {cmd_mode, cmd_shift_en, cmd_piped} == {dsp_mode, dsp_shift_enable, dsp_piped_final_addition};
    // A config change waits for an empty pipe plus four start-free cycles so DSP return timing never mixes configs.
    assign cmd_ready = !rst && used < (AW+2)'(FIFO_DEPTH) &&
                       (illegal || cfg_match || (inflight == '0 && quiet_cnt >= 3'd4));
    assign accept    = cmd_valid && cmd_ready;
    assign issue     = accept && !illegal;
    assign push      = dsp_compare_res && inflight != '0;
    assign res_valid = count != '0;
    assign pop       = res_valid && res_ready;
    assign res_data  = res_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dsp_start                <= 1'b0;
            dsp_mac                  <= 1'b0;
            dsp_shift_enable         <= 1'b0;
            dsp_shift_dir            <= 1'b0;
            dsp_piped_final_addition <= 1'b0;
            dsp_aa                   <= '0;
            dsp_bb                   <= '0;
            dsp_cc                   <= '0;
            dsp_mode                 <= 2'b00;
            dsp_shift_amount         <= '0;
            quiet_cnt                <= 3'd7;
            inflight                 <= '0;
            count                    <= '0;
            wr_ptr                   <= '0;
            rd_ptr                   <= '0;
            err_illegal              <= 1'b0;
            err_spurious             <= 1'b0;
        end else begin
            dsp_start <= issue;
            if (issue) begin
                dsp_mac                  <= cmd_mac;
                dsp_shift_enable         <= cmd_shift_en;
                dsp_shift_dir            <= cmd_shift_dir;
                dsp_piped_final_addition <= cmd_piped;
                dsp_aa                   <= cmd_a;
                dsp_bb                   <= cmd_b;
                dsp_cc                   <= cmd_c;
                dsp_mode                 <= cmd_mode;
                dsp_shift_amount         <= cmd_shift_amt;
            end
            // Zero during the dsp_start cycle, then counts start-free cycles up to 7.
            quiet_cnt    <= issue ? 3'd0 : quiet_cnt + {2'b00, quiet_cnt != 3'd7};
            inflight     <= inflight + (AW+1)'(issue) - (AW+1)'(push);
            count        <= count + (AW+1)'(push) - (AW+1)'(pop);
            wr_ptr       <= wr_ptr + AW'(push);
            rd_ptr       <= rd_ptr + AW'(pop);
            err_illegal  <= err_illegal | (accept && illegal);
            err_spurious <= err_spurious | (dsp_compare_res && inflight == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= dsp_out;
    end
endmodule

// File: tb/tb_dsp_op_sequencer.sv
// tb_dsp_op_sequencer: directed and randomized checks of dsp_op_sequencer against a latency-accurate DSP stub
module tb_dsp_op_sequencer;
    localparam int D = 4;

    typedef struct {
        logic [1:0]  mode;
        logic        mac, se, dir, pp;
        logic [1:0]  amt;
        logic [15:0] a, b;
        logic [31:0] c;
    } cmd_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [15:0] cmd_a = '0, cmd_b = '0;
    logic [31:0] cmd_c = '0;
    logic [1:0]  cmd_mode = '0, cmd_shift_amt = '0;
    logic        cmd_mac = 1'b0, cmd_shift_en = 1'b0, cmd_shift_dir = 1'b0, cmd_piped = 1'b0;
    logic        dsp_start, dsp_mac, dsp_shift_enable, dsp_shift_dir, dsp_piped_final_addition;
    logic [15:0] dsp_aa, dsp_bb;
    logic [31:0] dsp_cc;
    logic [1:0]  dsp_mode, dsp_shift_amount;
    logic        dsp_compare_res = 1'b0;
    logic [31:0] dsp_out = '0;
    logic        res_valid, res_ready = 1'b0;
    logic [31:0] res_data;
    logic        err_illegal, err_spurious;

    int          checks = 0, passed = 0, cyc = 0, starts = 0;
    logic [31:0] got_q[$];
    bit          force_cr = 1'b0;
    bit          sv[16];
    logic [31:0] sd[16];

    dsp_op_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c(cmd_c), .cmd_mode(cmd_mode),
        .cmd_mac(cmd_mac), .cmd_shift_en(cmd_shift_en), .cmd_shift_dir(cmd_shift_dir),
        .cmd_piped(cmd_piped), .cmd_shift_amt(cmd_shift_amt),
        .dsp_start(dsp_start), .dsp_mac(dsp_mac), .dsp_shift_enable(dsp_shift_enable),
        .dsp_shift_dir(dsp_shift_dir), .dsp_piped_final_addition(dsp_piped_final_addition),
        .dsp_aa(dsp_aa), .dsp_bb(dsp_bb), .dsp_cc(dsp_cc), .dsp_mode(dsp_mode),
        .dsp_shift_amount(dsp_shift_amount),
        .dsp_compare_res(dsp_compare_res), .dsp_out(dsp_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .err_illegal(err_illegal), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    function automatic int lat(input logic [1:0] m, input logic se, input logic pp);
        return (m == 2'd0 ? 0 : m == 2'd1 ? 1 : 3) + ((pp && !se) ? 3 : 0);
    endfunction

    function automatic logic [31:0] calc(input logic [15:0] a, input logic [15:0] b, input logic [31:0] c);
        logic signed [31:0] p;
        p = $signed(a) * $signed(b);
        return p + c;
    endfunction

    // Pop collector and start counter.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && res_valid && res_ready) got_q.push_back(res_data);
        if (dsp_start) starts++;
    end

    // DSP stub: returns a*b+c exactly k cycles after the start cycle (k=0 means same cycle).
    always @(negedge clk) begin
        int k;
        if (dsp_start) begin
            k = lat(dsp_mode, dsp_shift_enable, dsp_piped_final_addition);
            sv[(cyc + k) % 16] = 1'b1;
            sd[(cyc + k) % 16] = calc(dsp_aa, dsp_bb, dsp_cc);
        end
        dsp_compare_res = sv[cyc % 16] | force_cr;
        dsp_out = sv[cyc % 16] ? sd[cyc % 16] : 32'hDEAD_BEEF;
        sv[cyc % 16] = 1'b0;
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic apply(input cmd_t c);
        cmd_mode = c.mode; cmd_mac = c.mac; cmd_shift_en = c.se; cmd_shift_dir = c.dir;
        cmd_piped = c.pp; cmd_shift_amt = c.amt; cmd_a = c.a; cmd_b = c.b; cmd_c = c.c;
    endtask

    function automatic cmd_t mk(input logic [1:0] m, input logic se, input logic pp,
                                input logic [15:0] a, input logic [15:0] b, input logic [31:0] c);
        cmd_t n;
        n.mode = m; n.se = se; n.pp = pp; n.a = a; n.b = b; n.c = c;
        n.mac = 1'($urandom_range(0, 1)); n.dir = 1'($urandom_range(0, 1)); n.amt = 2'($urandom_range(0, 3));
        return n;
    endfunction

    function automatic cmd_t new_cmd(input cmd_t p);
        cmd_t n;
        n = mk(p.mode, p.se, p.pp, 16'($urandom), 16'($urandom), $urandom);
        if (p.mode == 2'd3 || $urandom_range(0, 4) == 0) begin
            n.mode = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            n.se = 1'($urandom_range(0, 1));
            n.pp = 1'($urandom_range(0, 1));
        end
        return n;
    endfunction

    // Holds the command until accepted; waits = stalled cycles, -1 on timeout. Returns in the cycle after acceptance.
    task automatic send(input cmd_t c, output int waits);
        apply(c);
        cmd_valid = 1'b1;
        waits = 0;
        @(negedge clk); #1;
        while (!cmd_ready && waits < 100) begin
            waits++;
            @(negedge clk); #1;
        end
        if (!cmd_ready) waits = -1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0; force_cr = 1'b0;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply(mk(2'd0, 1'b0, 1'b0, 16'd1, 16'd1, 32'd1));
        cmd_valid = 1'b1;
        step(); step();
        checks++; if (cmd_ready !== 1'b0) $display("FAIL rst_cmd_ready got=%b exp=0", cmd_ready); else passed++;
        checks++;
        if ({dsp_start, dsp_mac, dsp_shift_enable, dsp_shift_dir, dsp_piped_final_addition, dsp_mode, dsp_shift_amount} !== 9'd0)
            $display("FAIL rst_dsp_ctrl got=%b exp=0", {dsp_start, dsp_mac, dsp_shift_enable, dsp_shift_dir, dsp_piped_final_addition, dsp_mode, dsp_shift_amount});
        else passed++;
        checks++; if ({dsp_aa, dsp_bb, dsp_cc} !== 64'd0) $display("FAIL rst_dsp_data got=%h exp=0", {dsp_aa, dsp_bb, dsp_cc}); else passed++;
        checks++; if ({res_valid, res_data, err_illegal, err_spurious} !== 35'd0)
            $display("FAIL rst_res_err got=%h exp=0", {res_valid, res_data, err_illegal, err_spurious}); else passed++;
        cmd_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_mode00();
        int w;
        do_reset();
        res_ready = 1'b1;
        send(mk(2'd0, 1'b0, 1'b0, 16'd3, 16'd5, 32'd7), w);
        checks++; if (w !== 0) $display("FAIL m00_waits got=%0d exp=0", w); else passed++;
        checks++; if ({dsp_start, dsp_aa, dsp_bb, dsp_cc} !== {1'b1, 16'd3, 16'd5, 32'd7})
            $display("FAIL m00_issue got=%h exp=%h", {dsp_start, dsp_aa, dsp_bb, dsp_cc}, {1'b1, 16'd3, 16'd5, 32'd7}); else passed++;
        checks++; if (res_valid !== 1'b0) $display("FAIL m00_early got=%b exp=0", res_valid); else passed++;
        step();
        checks++; if ({res_valid, res_data} !== {1'b1, 32'd22}) $display("FAIL m00_result got=%b/%0d exp=1/22", res_valid, res_data); else passed++;
        checks++; if (dsp_start !== 1'b0) $display("FAIL m00_start_pulse got=%b exp=0", dsp_start); else passed++;
        step();
        checks++; if (res_valid !== 1'b0) $display("FAIL m00_popped got=%b exp=0", res_valid); else passed++;
    endtask

    task automatic test_mode10_piped();
        int w, early = 0;
        do_reset();
        res_ready = 1'b1;
        send(mk(2'd2, 1'b0, 1'b1, 16'hFFFE, 16'd1000, 32'd0), w);
        checks++; if (w !== 0) $display("FAIL m10_waits got=%0d exp=0", w); else passed++;
        for (int i = 0; i < 6; i++) begin
            step();
            if (res_valid) early++;
        end
        checks++; if (early !== 0) $display("FAIL m10_early got=%0d exp=0", early); else passed++;
        step();
        checks++; if ({res_valid, res_data} !== {1'b1, 32'hFFFFF830})
            $display("FAIL m10_result got=%b/%h exp=1/fffff830", res_valid, res_data); else passed++;
        step();
    endtask

    task automatic test_back_to_back();
        cmd_t cs[8];
        logic [31:0] ex[8];
        int w, tw = 0, stall = 0, base, bad = 0;
        do_reset();
        base = got_q.size();
        res_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cs[i] = mk(2'd1, 1'b0, 1'b0, 16'($urandom), 16'($urandom), $urandom);
            ex[i] = calc(cs[i].a, cs[i].b, cs[i].c);
        end
        for (int i = 0; i < 4; i++) begin
            send(cs[i], w);
            tw += (w < 0) ? 1000 : w;
        end
        checks++; if (tw !== 0) $display("FAIL b2b_first4_waits got=%0d exp=0", tw); else passed++;
        apply(cs[4]);
        cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (cmd_ready) stall++;
            step();
        end
        checks++; if (stall !== 0) $display("FAIL b2b_credit_stall ready_cycles=%0d exp=0", stall); else passed++;
        checks++; if (res_valid !== 1'b1) $display("FAIL b2b_full_valid got=%b exp=1", res_valid); else passed++;
        res_ready = 1'b1;
        for (int i = 4; i < 8; i++) begin
            send(cs[i], w);
            if (w < 0) bad++;
        end
        checks++; if (bad !== 0) $display("FAIL b2b_last4_timeouts got=%0d exp=0", bad); else passed++;
        for (int t = 0; t < 50 && got_q.size() - base < 8; t++) step();
        checks++; if (got_q.size() - base !== 8) $display("FAIL b2b_count got=%0d exp=8", got_q.size() - base); else passed++;
        for (int i = 0; i < 8; i++) begin
            if (base + i < got_q.size()) begin
                checks++; if (got_q[base + i] !== ex[i]) $display("FAIL b2b_data[%0d] got=%h exp=%h", i, got_q[base + i], ex[i]); else passed++;
            end
        end
    endtask

    task automatic test_cfg_change();
        cmd_t c0, c1;
        int w0, w1, base;
        do_reset();
        base = got_q.size();
        res_ready = 1'b1;
        c0 = mk(2'd0, 1'b0, 1'b0, 16'($urandom), 16'($urandom), $urandom);
        c1 = mk(2'd2, 1'b0, 1'b0, 16'($urandom), 16'($urandom), $urandom);
        send(c0, w0);
        send(c1, w1);
        checks++; if (w0 !== 0) $display("FAIL cfg_first_waits got=%0d exp=0", w0); else passed++;
        checks++; if (w1 !== 4) $display("FAIL cfg_switch_waits got=%0d exp=4", w1); else passed++;
        for (int i = 0; i < 10; i++) step();
        checks++; if (got_q.size() - base !== 2) $display("FAIL cfg_count got=%0d exp=2", got_q.size() - base); else passed++;
        if (got_q.size() - base >= 2) begin
            checks++; if (got_q[base] !== calc(c0.a, c0.b, c0.c)) $display("FAIL cfg_data0 got=%h exp=%h", got_q[base], calc(c0.a, c0.b, c0.c)); else passed++;
            checks++; if (got_q[base + 1] !== calc(c1.a, c1.b, c1.c)) $display("FAIL cfg_data1 got=%h exp=%h", got_q[base + 1], calc(c1.a, c1.b, c1.c)); else passed++;
        end
        checks++; if (err_spurious !== 1'b0) $display("FAIL cfg_spurious got=%b exp=0", err_spurious); else passed++;
    endtask

    task automatic test_illegal();
        int w, s0;
        do_reset();
        res_ready = 1'b1;
        s0 = starts;
        send(mk(2'd3, 1'b1, 1'b1, 16'd9, 16'd9, 32'd9), w);
        checks++; if (w !== 0) $display("FAIL ill_waits got=%0d exp=0", w); else passed++;
        checks++; if (err_illegal !== 1'b1) $display("FAIL ill_flag got=%b exp=1", err_illegal); else passed++;
        for (int i = 0; i < 10; i++) step();
        checks++; if (starts - s0 !== 0) $display("FAIL ill_starts got=%0d exp=0", starts - s0); else passed++;
        checks++; if ({res_valid, dsp_mode, dsp_shift_enable, dsp_piped_final_addition} !== 5'd0)
            $display("FAIL ill_no_effect got=%b exp=0", {res_valid, dsp_mode, dsp_shift_enable, dsp_piped_final_addition}); else passed++;
        checks++; if (err_illegal !== 1'b1) $display("FAIL ill_sticky got=%b exp=1", err_illegal); else passed++;
    endtask

    task automatic test_spurious();
        do_reset();
        res_ready = 1'b0;
        step();
        force_cr = 1'b1;
        step();
        force_cr = 1'b0;
        checks++; if (err_spurious !== 1'b1) $display("FAIL spur_flag got=%b exp=1", err_spurious); else passed++;
        checks++; if (res_valid !== 1'b0) $display("FAIL spur_no_push got=%b exp=0", res_valid); else passed++;
        step(); step(); step();
        checks++; if ({err_spurious, err_illegal, res_valid} !== 3'b100)
            $display("FAIL spur_sticky got=%b exp=100", {err_spurious, err_illegal, res_valid}); else passed++;
    endtask

    task automatic test_random();
        cmd_t c, last;
        int outst = 0, infl = 0, ret = 0, ill = 0, start_cyc, base;
        logic [3:0] ccfg = 4'd0;
        bit exp_start = 1'b0, pred, acc, pop, rt;
        logic [31:0] exp_q[$], all_q[$];
        do_reset();
        base = got_q.size();
        start_cyc = cyc - 100;
        c = new_cmd(mk(2'd0, 1'b0, 1'b0, 16'd0, 16'd0, 32'd0));
        last = c;
        apply(c);
        for (int n = 0; n < 400; n++) begin
            if (!cmd_valid && n < 360 && $urandom_range(0, 3) != 0) begin
                c = new_cmd(c);
                apply(c);
                cmd_valid = 1'b1;
            end
            res_ready = $urandom_range(0, 2) != 0;
            @(negedge clk); #1;
            checks++; if (dsp_start !== exp_start) $display("FAIL rnd_start cyc=%0d got=%b exp=%b", cyc, dsp_start, exp_start); else passed++;
            if (exp_start) begin
                checks++;
                if ({dsp_aa, dsp_bb, dsp_cc, dsp_mode, dsp_mac, dsp_shift_enable, dsp_shift_dir, dsp_piped_final_addition, dsp_shift_amount} !==
                    {last.a, last.b, last.c, last.mode, last.mac, last.se, last.dir, last.pp, last.amt})
                    $display("FAIL rnd_fields cyc=%0d got=%h/%h/%h m%0d exp=%h/%h/%h m%0d", cyc, dsp_aa, dsp_bb, dsp_cc, dsp_mode, last.a, last.b, last.c, last.mode);
                else passed++;
            end
            pred = outst < D && (c.mode == 2'd3 || {c.mode, c.se, c.pp} == ccfg || (infl == 0 && cyc - start_cyc >= 4));
            checks++; if (cmd_ready !== pred) $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, cmd_ready, pred); else passed++;
            checks++; if (res_valid !== (ret > 0)) $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, res_valid, ret > 0); else passed++;
            if (ret > 0 && exp_q.size() > 0) begin
                checks++; if (res_data !== exp_q[0]) $display("FAIL rnd_data cyc=%0d got=%h exp=%h", cyc, res_data, exp_q[0]); else passed++;
            end
            acc = cmd_valid && cmd_ready;
            pop = res_valid && res_ready;
            rt = dsp_compare_res && infl > 0;
            exp_start = 1'b0;
            if (acc && c.mode == 2'd3) ill++;
            if (acc && c.mode != 2'd3) begin
                outst++; infl++;
                ccfg = {c.mode, c.se, c.pp};
                start_cyc = cyc + 1;
                exp_q.push_back(calc(c.a, c.b, c.c));
                all_q.push_back(calc(c.a, c.b, c.c));
                exp_start = 1'b1;
                last = c;
            end
            if (rt) begin infl--; ret++; end
            if (pop) begin
                outst--; ret--;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            step();
            if (acc) cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        for (int t = 0; t < 100 && got_q.size() - base < all_q.size(); t++) step();
        step();
        checks++; if (got_q.size() - base !== all_q.size()) $display("FAIL rnd_count got=%0d exp=%0d", got_q.size() - base, all_q.size()); else passed++;
        for (int i = 0; i < all_q.size() && base + i < got_q.size(); i++) begin
            checks++; if (got_q[base + i] !== all_q[i]) $display("FAIL rnd_order[%0d] got=%h exp=%h", i, got_q[base + i], all_q[i]); else passed++;
        end
        checks++; if ({err_illegal, err_spurious} !== {ill > 0, 1'b0}) $display("FAIL rnd_errs got=%b exp=%b0", {err_illegal, err_spurious}, ill > 0); else passed++;
    endtask

    task automatic test_reset_midop();
        int w, tw = 0;
        do_reset();
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(mk(2'd2, 1'b0, 1'b0, 16'($urandom), 16'($urandom), $urandom), w);
            tw += (w < 0) ? 1000 : w;
        end
        checks++; if (tw !== 0) $display("FAIL mid_waits got=%0d exp=0", tw); else passed++;
        step(); step();
        checks++; if (res_valid !== 1'b1) $display("FAIL mid_prefill got=%b exp=1", res_valid); else passed++;
        rst = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b0) $display("FAIL mid_rst_ready got=%b exp=0", cmd_ready); else passed++;
        checks++;
        if ({dsp_start, dsp_mac, dsp_shift_enable, dsp_shift_dir, dsp_piped_final_addition, dsp_mode, dsp_shift_amount, dsp_aa, dsp_bb, dsp_cc} !== 73'd0)
            $display("FAIL mid_rst_dsp got=%h exp=0", {dsp_start, dsp_mode, dsp_aa, dsp_bb, dsp_cc}); else passed++;
        checks++; if ({res_valid, res_data, err_illegal, err_spurious} !== 35'd0)
            $display("FAIL mid_rst_res got=%h exp=0", {res_valid, res_data, err_illegal, err_spurious}); else passed++;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step();
        checks++; if ({err_spurious, res_valid, dsp_start} !== 3'b100)
            $display("FAIL mid_late_return got=%b exp=100", {err_spurious, res_valid, dsp_start}); else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mode00();
        test_mode10_piped();
        test_back_to_back();
        test_cfg_change();
        test_random();
        test_illegal();
        test_spurious();
        test_reset_midop();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
